// File: rtl/rv_p4_pkg.sv
// Shared widths, TX cell payload and distributor FSM encoding for the RV-P4 datapath.
package rv_p4_pkg;

  localparam int unsigned NUM_PORTS = 32;
  localparam int unsigned CELL_W    = 512;
  localparam int unsigned PORT_W    = 5;
  localparam int unsigned LEN_W     = 7;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic              sof;
    logic              eof;
    logic [LEN_W-1:0]  eop_len;
    logic [CELL_W-1:0] data;
  } tx_cell_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_DROP = 2'd2
  } tx_dist_state_t;

endpackage

// File: rtl/mac_tx_skid.sv
// Two-entry FIFO-ordered skid buffer of TX cells; head and ready come straight from flops.
module mac_tx_skid
  import rv_p4_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  tx_cell_t push_cell,
  output logic     ready,
  output logic     head_valid,
  output tx_cell_t head,
  input  logic     pop_ready
);

  tx_cell_t   ent0_q, ent0_d;
  tx_cell_t   ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  logic       pop_c;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    cnt_d   = cnt_q;
    pop_c   = (cnt_q != 2'd0) && pop_ready;
    unique case (cnt_q)
      2'd0: begin
        if (push) begin
          ent0_d = push_cell;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop_c) begin
          ent0_d = push_cell;
        end else if (push) begin
          ent1_d = push_cell;
          cnt_d  = 2'd2;
        end else if (pop_c) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        // Full: ready is low, so only a pop can happen here.
        if (pop_c) begin
          ent0_d = ent1_q;
          cnt_d  = 2'd1;
        end
      end
    endcase
    ready_d = (cnt_d < 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      cnt_q   <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready      = ready_q;
  assign head_valid = (cnt_q != 2'd0);
  assign head       = ent0_q;

endmodule

// File: rtl/mac_tx_dist.sv
// Steers each frame of the deparser cell stream to the TX MAC port locked at SOF.
// Optional statistics counters are built when MAC_TX_DIST_STATS_EN is defined.
module mac_tx_dist
  import rv_p4_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PORT_W-1:0]                   in_port,
  input  logic                                in_sof,
  input  logic                                in_eof,
  input  logic [LEN_W-1:0]                    in_eop_len,
  input  logic [CELL_W-1:0]                   in_data,
  output logic [NUM_PORTS-1:0]                tx_valid,
  input  logic [NUM_PORTS-1:0]                tx_ready,
  output logic [NUM_PORTS-1:0]                tx_sof,
  output logic [NUM_PORTS-1:0]                tx_eof,
  output logic [NUM_PORTS-1:0][LEN_W-1:0]     tx_eop_len,
  output logic [NUM_PORTS-1:0][CELL_W-1:0]    tx_data,
  output logic                                err_drop,
  input  logic [PORT_W-1:0]                   stat_rd_port,
  output logic [31:0]                         stat_rd_frames,
  output logic [15:0]                         stat_drop_frames
);

  tx_dist_state_t    state_q, state_d;
  logic [PORT_W-1:0] lock_port_q, lock_port_d;
  logic              err_drop_q, err_drop_d;
  logic              hs_c;
  logic              push_c;
  logic              port_legal_c;
  tx_cell_t          push_cell;
  logic              head_valid;
  tx_cell_t          head;
  logic              pop_ready_c;
  logic              tx_done_c;

  assign hs_c         = in_valid && in_ready;
  assign port_legal_c = ({1'b0, in_port} < (PORT_W + 1)'(NUM_PORTS));

  // Input framing FSM; moves only on an accepted cell.
  always_comb begin
    state_d        = state_q;
    lock_port_d    = lock_port_q;
    err_drop_d     = 1'b0;
    push_c         = 1'b0;
    push_cell      = '{port: lock_port_q, sof: in_sof, eof: in_eof,
                       eop_len: in_eop_len, data: in_data};
    if (hs_c) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_sof && port_legal_c) begin
            lock_port_d    = in_port;
            push_cell.port = in_port;
            push_c         = 1'b1;
            state_d        = in_eof ? S_IDLE : S_FWD;
          end else begin
            err_drop_d = 1'b1;
            state_d    = in_eof ? S_IDLE : S_DROP;
          end
        end
        S_FWD: begin
          // A stray SOF mid-frame is flagged but still forwarded on the locked port.
          push_c     = 1'b1;
          err_drop_d = in_sof;
          if (in_eof) state_d = S_IDLE;
        end
        S_DROP: begin
          if (in_eof) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lock_port_q <= '0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
      err_drop_q  <= err_drop_d;
    end
  end

  assign err_drop = err_drop_q;

  mac_tx_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (push_c),
    .push_cell  (push_cell),
    .ready      (in_ready),
    .head_valid (head_valid),
    .head       (head),
    .pop_ready  (pop_ready_c)
  );

  assign pop_ready_c = tx_ready[head.port];
  assign tx_done_c   = head_valid && pop_ready_c && head.eof;

  // Head cell drives only its own port; all others stay at zero.
  always_comb begin
    tx_valid   = '0;
    tx_sof     = '0;
    tx_eof     = '0;
    tx_eop_len = '0;
    tx_data    = '0;
    if (head_valid) begin
      tx_valid[head.port]   = 1'b1;
      tx_sof[head.port]     = head.sof;
      tx_eof[head.port]     = head.eof;
      tx_eop_len[head.port] = head.eop_len;
      tx_data[head.port]    = head.data;
    end
  end

`ifdef MAC_TX_DIST_STATS_EN
  logic [31:0] frames_q [NUM_PORTS];
  logic [31:0] frames_d [NUM_PORTS];
  logic [31:0] rd_frames_q, rd_frames_d;
  logic [15:0] drop_q, drop_d;

  always_comb begin
    frames_d = frames_q;
    if (tx_done_c) frames_d[head.port] = frames_q[head.port] + 32'd1;
    drop_d      = (err_drop_d && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    rd_frames_d = frames_q[stat_rd_port];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_PORTS); i++) frames_q[i] <= '0;
      rd_frames_q <= '0;
      drop_q      <= '0;
    end else begin
      frames_q    <= frames_d;
      rd_frames_q <= rd_frames_d;
      drop_q      <= drop_d;
    end
  end

  assign stat_rd_frames   = rd_frames_q;
  assign stat_drop_frames = drop_q;
`else
  logic unused_stats_c;
  assign unused_stats_c   = ^{tx_done_c, stat_rd_port};
  assign stat_rd_frames   = '0;
  assign stat_drop_frames = '0;
`endif

endmodule

// File: tb/tb_mac_tx_dist.sv
// Directed self-checking bench for mac_tx_dist: vector table plus backpressure, stats and reset sequences.
module tb_mac_tx_dist;
  import rv_p4_pkg::*;

  logic                              clk;
  logic                              rst;
  logic                              in_valid;
  logic                              in_ready;
  logic [PORT_W-1:0]                 in_port;
  logic                              in_sof;
  logic                              in_eof;
  logic [LEN_W-1:0]                  in_eop_len;
  logic [CELL_W-1:0]                 in_data;
  logic [NUM_PORTS-1:0]              tx_valid;
  logic [NUM_PORTS-1:0]              tx_ready;
  logic [NUM_PORTS-1:0]              tx_sof;
  logic [NUM_PORTS-1:0]              tx_eof;
  logic [NUM_PORTS-1:0][LEN_W-1:0]   tx_eop_len;
  logic [NUM_PORTS-1:0][CELL_W-1:0]  tx_data;
  logic                              err_drop;
  logic [PORT_W-1:0]                 stat_rd_port;
  logic [31:0]                       stat_rd_frames;
  logic [15:0]                       stat_drop_frames;

  int checks = 0;
  int errors = 0;

  mac_tx_dist dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_port          (in_port),
    .in_sof           (in_sof),
    .in_eof           (in_eof),
    .in_eop_len       (in_eop_len),
    .in_data          (in_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_sof           (tx_sof),
    .tx_eof           (tx_eof),
    .tx_eop_len       (tx_eop_len),
    .tx_data          (tx_data),
    .err_drop         (err_drop),
    .stat_rd_port     (stat_rd_port),
    .stat_rd_frames   (stat_rd_frames),
    .stat_drop_frames (stat_drop_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        sof;
    logic        eof;
    logic [4:0]  port;
    logic [6:0]  len;
    logic [31:0] tag;
    logic [31:0] exp_mask;
    logic        exp_sof;
    logic        exp_eof;
    logic [6:0]  exp_len;
    logic [31:0] exp_tag;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

`ifdef MAC_TX_DIST_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic chk(input string name, input logic [CELL_W-1:0] act, input logic [CELL_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [4:0] p,
                       input logic [6:0] l, input logic [31:0] tag);
    in_valid   = v;
    in_sof     = s;
    in_eof     = e;
    in_port    = p;
    in_eop_len = l;
    in_data    = {16{tag}};
  endtask

  function automatic vec_t mk(logic v, logic s, logic e, logic [4:0] p, logic [6:0] l, logic [31:0] tag,
                              logic [31:0] m, logic es, logic ee, logic [6:0] el, logic [31:0] et, logic er);
    vec_t r;
    r.vld = v; r.sof = s; r.eof = e; r.port = p; r.len = l; r.tag = tag;
    r.exp_mask = m; r.exp_sof = es; r.exp_eof = ee; r.exp_len = el; r.exp_tag = et; r.exp_err = er;
    return r;
  endfunction

  function automatic int onehot_idx(logic [31:0] m);
    for (int i = 0; i < 32; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic bit others_zero(int keep);
    for (int i = 0; i < 32; i++)
      if (i != keep && (tx_sof[i] || tx_eof[i] || tx_eop_len[i] != 0 || tx_data[i] != 0)) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int          bp_port [5];
    logic        bp_sof  [5];
    logic        bp_eof  [5];
    int          acc;
    int          popn;
    bit          seen_low;
    bit          accepted;
    int          idx;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, 32'h0);
    tx_ready     = '1;
    stat_rd_port = 5'd0;

    vecs[0]  = mk(0, 0, 0, 5'd0,  7'd0,  32'h00, 32'h0,        0, 0, 7'd0,  32'h00, 0);
    vecs[1]  = mk(1, 1, 1, 5'd7,  7'd60, 32'hA1, 32'h1 << 7,   1, 1, 7'd60, 32'hA1, 0);
    vecs[2]  = mk(1, 1, 0, 5'd3,  7'd0,  32'hB1, 32'h1 << 3,   1, 0, 7'd0,  32'hB1, 0);
    vecs[3]  = mk(1, 0, 0, 5'd9,  7'd0,  32'hB2, 32'h1 << 3,   0, 0, 7'd0,  32'hB2, 0);
    vecs[4]  = mk(1, 0, 0, 5'd9,  7'd0,  32'hB3, 32'h1 << 3,   0, 0, 7'd0,  32'hB3, 0);
    vecs[5]  = mk(1, 0, 1, 5'd9,  7'd17, 32'hB4, 32'h1 << 3,   0, 1, 7'd17, 32'hB4, 0);
    vecs[6]  = mk(1, 0, 0, 5'd4,  7'd0,  32'hC0, 32'h0,        0, 0, 7'd0,  32'h00, 1);
    vecs[7]  = mk(1, 0, 1, 5'd4,  7'd9,  32'hC1, 32'h0,        0, 0, 7'd0,  32'h00, 0);
    vecs[8]  = mk(1, 1, 0, 5'd12, 7'd0,  32'hD1, 32'h1 << 12,  1, 0, 7'd0,  32'hD1, 0);
    vecs[9]  = mk(1, 0, 1, 5'd12, 7'd5,  32'hD2, 32'h1 << 12,  0, 1, 7'd5,  32'hD2, 0);
    vecs[10] = mk(0, 0, 0, 5'd0,  7'd0,  32'h00, 32'h0,        0, 0, 7'd0,  32'h00, 0);
    vecs[11] = mk(1, 1, 0, 5'd20, 7'd0,  32'hE1, 32'h1 << 20,  1, 0, 7'd0,  32'hE1, 0);
    vecs[12] = mk(1, 1, 0, 5'd2,  7'd0,  32'hE2, 32'h1 << 20,  1, 0, 7'd0,  32'hE2, 1);
    vecs[13] = mk(1, 0, 1, 5'd2,  7'd0,  32'hE3, 32'h1 << 20,  0, 1, 7'd0,  32'hE3, 0);

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_err_drop", err_drop, 0);
    chk("rst_drop_cnt", stat_drop_frames, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Table vectors with all ports ready
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].vld, vecs[i].sof, vecs[i].eof, vecs[i].port, vecs[i].len, vecs[i].tag);
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      tick();
      chk($sformatf("v%0d_tx_valid", i), tx_valid, vecs[i].exp_mask);
      chk($sformatf("v%0d_err_drop", i), err_drop, vecs[i].exp_err);
      idx = onehot_idx(vecs[i].exp_mask);
      if (idx >= 0) begin
        chk($sformatf("v%0d_sof", i), tx_sof[idx], vecs[i].exp_sof);
        chk($sformatf("v%0d_eof", i), tx_eof[idx], vecs[i].exp_eof);
        chk($sformatf("v%0d_eop_len", i), tx_eop_len[idx], vecs[i].exp_len);
        chk($sformatf("v%0d_data", i), tx_data[idx], {16{vecs[i].exp_tag}});
      end
      chk($sformatf("v%0d_idle_ports_zero", i), others_zero(idx), 1);
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, 32'h0);
    tick();
    chk("tbl_drop_cnt", stat_drop_frames, STATS ? 16'd2 : 16'd0);

    // Back-to-back frames with port 0 stalled for 5 cycles
    bp_port = '{0, 0, 0, 31, 31};
    bp_sof  = '{1, 0, 0, 1, 0};
    bp_eof  = '{0, 0, 1, 0, 1};
    acc = 0; popn = 0; seen_low = 0;
    for (int c = 0; c < 60 && popn < 5; c++) begin
      tx_ready = (c < 5) ? ~32'h1 : '1;
      if (acc < 5) drive(1'b1, bp_sof[acc], bp_eof[acc], 5'(bp_port[acc]), 7'd0, 32'h100 + 32'(acc));
      else         drive(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, 32'h0);
      if (!in_ready && !seen_low) begin
        seen_low = 1;
        chk("bp_accepts_before_full", 32'(acc), 32'd2);
      end
      if (c == 5) chk("bp_ready_lags_pop", in_ready, 0);
      if ((tx_valid & tx_ready) != 0) begin
        idx = onehot_idx(tx_valid);
        chk($sformatf("bp_pop%0d_onehot", popn), 32'($countones(tx_valid)), 32'd1);
        chk($sformatf("bp_pop%0d_port", popn), 32'(idx), 32'(bp_port[popn]));
        chk($sformatf("bp_pop%0d_tag", popn), tx_data[idx][31:0], 32'h100 + 32'(popn));
        popn++;
      end
      accepted = in_valid && in_ready;
      tick();
      if (accepted) acc++;
    end
    chk("bp_all_popped", 32'(popn), 32'd5);
    chk("bp_saw_full", seen_low, 1);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, 32'h0);
    tx_ready = '1;

    // 100 single-cell frames to port 5
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, 1'b1, 5'd5, 7'd0, 32'(i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, 32'h0);
    tick();
    stat_rd_port = 5'd5;
    tick();
    chk("stat_port5_frames", stat_rd_frames, STATS ? 32'd100 : 32'd0);
    stat_rd_port = 5'd7;
    tick();
    chk("stat_port7_frames", stat_rd_frames, STATS ? 32'd1 : 32'd0);
    stat_rd_port = 5'd5;

    // Reset mid-frame
    drive(1'b1, 1'b1, 1'b0, 5'd5, 7'd0, 32'h55);
    tick();
    chk("mid_frame_valid", tx_valid, 32'h1 << 5);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, 32'h0);
    rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", tx_valid, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_drop_cnt", stat_drop_frames, 0);
    chk("async_rst_rd_frames", stat_rd_frames, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rerst_in_ready", in_ready, 1);
    drive(1'b1, 1'b0, 1'b1, 5'd5, 7'd3, 32'h77);
    tick();
    chk("rerst_orphan_err", err_drop, 1);
    chk("rerst_orphan_valid", tx_valid, 0);
    chk("rerst_drop_cnt", stat_drop_frames, STATS ? 16'd1 : 16'd0);
    drive(1'b1, 1'b1, 1'b1, 5'd5, 7'd1, 32'h78);
    tick();
    chk("rerst_frame_valid", tx_valid, 32'h1 << 5);
    chk("rerst_frame_data", tx_data[5], {16{32'h78}});
    drive(1'b0, 1'b0, 1'b0, 5'd0, 7'd0, 32'h0);
    tick();
    tick();
    chk("rerst_port5_frames", stat_rd_frames, STATS ? 32'd1 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_tx_dist.md
# mac_tx_dist

Single-stream to 32-port MAC TX distributor: accepts the cell stream leaving the deparser and steers each frame to the TX MAC port named in its first cell. The destination port is latched at SOF and held until EOF, so the cells of a frame are never interleaved or split across ports. A two-entry skid buffer registers all outputs and `in_ready`, giving full throughput with no combinational ready path. Frames with an illegal port or a broken SOF/EOF framing are dropped and counted.

## Interface
- `NUM_PORTS`, 32: number of TX ports; the only legal value is 32, set by `rv_p4_pkg`.
- `CELL_W`, 512: cell data width in bits.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input cell valid.
- `in_ready` out 1: input may be accepted; registered.
- `in_port` in 5: destination port; sampled only on SOF cells.
- `in_sof` in 1: first cell of the frame.
- `in_eof` in 1: last cell of the frame.
- `in_eop_len` in 7: valid bytes in the EOF cell, 1..64; 0 encodes 64.
- `in_data` in 512: cell payload.
- `tx_valid` out [31:0]: per-port cell valid.
- `tx_ready` in [31:0]: per-port backpressure.
- `tx_sof`, `tx_eof` out [31:0]: per-port framing.
- `tx_eop_len` out [31:0][6:0]: per-port EOP length.
- `tx_data` out [31:0][511:0]: per-port payload.
- `err_drop` out 1: one-cycle pulse when a frame is dropped.
- `stat_rd_port` in 5: statistics read select.
- `stat_rd_frames` out 32: frames forwarded on `stat_rd_port`, valid one cycle after select.
- `stat_drop_frames` out 16: dropped-frame count, saturating.

## Operation
- Input FSM, advanced only on an input handshake (`in_valid && in_ready`):
  - `S_IDLE`, waiting for SOF:
    - SOF with `in_port < NUM_PORTS` → latch `lock_port`, push the cell, go to `S_FWD`, or stay in `S_IDLE` if `in_eof` is also set.
    - SOF with an illegal port → go to `S_DROP`, or stay in `S_IDLE` if `in_eof` is also set; pulse `err_drop`.
    - Non-SOF cell → discard it, go to `S_DROP` unless it is EOF, pulse `err_drop`.
  - `S_FWD`, locked on a port:
    - Every cell is pushed with `lock_port`; `in_port` is ignored.
    - EOF → go to `S_IDLE`.
    - SOF mid-frame → forward the cell unchanged and pulse `err_drop` (framing error). The lock is kept.
  - `S_DROP`: discard cells until EOF, then go to `S_IDLE`. `err_drop` pulses once per frame, on entry to `S_DROP`.
- Skid buffer, 2 entries {port, sof, eof, eop_len, data}, FIFO order.
  - The head drives `tx_*[head.port]` only; every other port sees valid=0 with data/sof/eof/eop_len = 0.
  - Pop on `tx_valid[head.port] && tx_ready[head.port]`.
- `in_ready` = entries < 2 after this cycle's pop and push, computed in a register.
- A blocked port stalls all ports (head-of-line blocking by design; the traffic manager schedules per port).
- Dropped cells are still accepted (`in_ready` governs) but never pushed.

## Timing
- Latency: a cell accepted in cycle N appears on `tx_*` in cycle N+1.
- Throughput: one cell per cycle with `tx_ready` held high.
- Simultaneous push and pop with one entry → occupancy stays 1 and `in_ready` stays 1.
- Full with a pop this cycle → `in_ready`=1 in the next cycle, not the same cycle.
- Reset values: FSM = `S_IDLE`; skid empty; every `tx_valid`=0; all `tx_*` data=0; `in_ready`=0 during reset and 1 in the first cycle after deassert; `err_drop`=0; all counters 0.
- Reset asserted mid-frame discards buffered cells. The next frame must start with SOF, or it is dropped.
- Counters: `stat_drop_frames` saturates at 0xFFFF. Frame counters wrap at 2^32.

## Configuration
- `MAC_TX_DIST_STATS_EN` defined:
  - 32×32-bit per-port frame counters, incremented on a TX handshake with EOF.
  - 16-bit drop counter.
  - `stat_rd_frames` is a registered read of the counter selected by `stat_rd_port`.
- Undefined: counters are not instantiated; `stat_rd_frames` and `stat_drop_frames` are tied 0. `err_drop` remains present.

## Structure
- In `rv_p4_pkg`: `NUM_PORTS`, `CELL_W`, a `tx_cell_t` struct {port[4:0], sof, eof, eop_len[6:0], data[511:0]}, and the FSM enum `tx_dist_state_t`.
- One sub-module, `mac_tx_skid`: 2-entry registered skid buffer of `tx_cell_t` with a registered ready. The FSM, output demux and stats live in `mac_tx_dist`.

## Test plan
- Single-cell frame (SOF+EOF, port 7, eop_len 60), `tx_ready`=all ones → `tx_valid[7]`=1 one cycle later with eop_len 60; no other port is valid.
- 4-cell frame to port 3 with `in_port` toggled to 9 on cells 2–4 → all four cells appear on port 3 only, in order, in consecutive cycles.
- Back-to-back frames (port 0, then port 31) with `tx_ready[0]` low for 5 cycles → `in_ready` falls after 2 cells, no cell is lost or reordered, and port 31 starts only after port 0's EOF.
- Orphan middle cell in `S_IDLE`, then a 2-cell frame → `err_drop` pulses once, the orphan never appears, and the following frame forwards normally; `stat_drop_frames`=1.
- With `MAC_TX_DIST_STATS_EN`, 100 frames to port 5 → `stat_rd_frames`=100 one cycle after `stat_rd_port`=5; reset mid-frame then clears all counters and outputs.
